idex_stage: RTL

IDEX_STAGE -- requirements
Module: idex_stage

---
 rtl/idex_stage_if.sv | 51 +++++
 rtl/idex_stage.sv | 138 +++++++++++++
 2 files changed

// File: rtl/idex_stage_if.sv
// Bundle of decode-side, forwarding, and execute-side signals for the ID/EX pipeline register.
// The slave modport is the stage's view; the master modport is the surrounding pipeline's view.
interface idex_stage_if;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [1:0]  id_aluop;
  logic        id_alusrc;
  logic        id_regwrite;
  logic        id_memread;
  logic        exm_regwrite;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [31:0] ex_store_data;
  logic [1:0]  ex_aluop;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memread;
  logic [15:0] stall_cnt;

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_aluop, id_alusrc, id_regwrite, id_memread,
           exm_regwrite, exm_rd, exm_result, wb_regwrite, wb_rd, wb_data,
           flush, ex_ready,
    output id_ready, ex_valid, ex_a, ex_b, ex_store_data, ex_aluop, ex_rd,
           ex_regwrite, ex_memread, stall_cnt
  );

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_aluop, id_alusrc, id_regwrite, id_memread,
           exm_regwrite, exm_rd, exm_result, wb_regwrite, wb_rd, wb_data,
           flush, ex_ready,
    input  id_ready, ex_valid, ex_a, ex_b, ex_store_data, ex_aluop, ex_rd,
           ex_regwrite, ex_memread, stall_cnt
  );
endinterface

// File: rtl/idex_stage.sv
// ID/EX pipeline register with valid/ready flow control, load-use bubble insertion,
// flush, and combinational EX/MEM and MEM/WB operand forwarding on the held instruction.
module idex_stage (
  input logic         clk,
  input logic         rst,
  idex_stage_if.slave bus
);
  logic        valid_q, valid_d;
  logic [31:0] rsData_q, rsData_d;
  logic [31:0] rtData_q, rtData_d;
  logic [31:0] imm_q, imm_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  aluop_q, aluop_d;
  logic        alusrc_q, alusrc_d;
  logic        regwrite_q, regwrite_d;
  logic        memread_q, memread_d;
  logic [15:0] stallCnt_q, stallCnt_d;

  logic        luh;
  logic        advance;
  logic        idReady;
  logic [31:0] fwdRs;
  logic [31:0] fwdRt;

  // EX/MEM wins over MEM/WB; register 0 is hard-wired and never forwarded.
  function automatic logic [31:0] forward(
    input logic [4:0]  idx,
    input logic [31:0] regData,
    input logic        exmWr,
    input logic [4:0]  exmRd,
    input logic [31:0] exmRes,
    input logic        wbWr,
    input logic [4:0]  wbRd,
    input logic [31:0] wbData
  );
    logic [31:0] result;
    result = regData;
    if (idx != 5'd0) begin
      if (exmWr && (exmRd == idx)) begin
        result = exmRes;
      end else if (wbWr && (wbRd == idx)) begin
        result = wbData;
      end
    end
    return result;
  endfunction

  assign luh     = valid_q & memread_q & (rd_q != 5'd0) &
                   ((rd_q == bus.id_rs) | (rd_q == bus.id_rt));
  assign advance = bus.ex_ready | ~valid_q;
  assign idReady = advance & ~luh & ~bus.flush;

  always_comb begin
    valid_d    = valid_q;
    rsData_d   = rsData_q;
    rtData_d   = rtData_q;
    imm_d      = imm_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    aluop_d    = aluop_q;
    alusrc_d   = alusrc_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    stallCnt_d = stallCnt_q;

    if (advance) begin
      valid_d    = bus.id_valid & idReady;
      rsData_d   = bus.id_rs_data;
      rtData_d   = bus.id_rt_data;
      imm_d      = bus.id_imm;
      rs_d       = bus.id_rs;
      rt_d       = bus.id_rt;
      rd_d       = bus.id_rd;
      aluop_d    = bus.id_aluop;
      alusrc_d   = bus.id_alusrc;
      regwrite_d = bus.id_regwrite;
      memread_d  = bus.id_memread;
    end

    if (bus.flush) begin
      valid_d = 1'b0;
    end

    // Only cycles that actually push a bubble downstream are counted.
    if (luh && bus.ex_ready && !bus.flush && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_d = stallCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      rsData_q   <= 32'd0;
      rtData_q   <= 32'd0;
      imm_q      <= 32'd0;
      rs_q       <= 5'd0;
      rt_q       <= 5'd0;
      rd_q       <= 5'd0;
      aluop_q    <= 2'd0;
      alusrc_q   <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      stallCnt_q <= 16'd0;
    end else begin
      valid_q    <= valid_d;
      rsData_q   <= rsData_d;
      rtData_q   <= rtData_d;
      imm_q      <= imm_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      aluop_q    <= aluop_d;
      alusrc_q   <= alusrc_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign fwdRs = forward(rs_q, rsData_q, bus.exm_regwrite, bus.exm_rd, bus.exm_result,
                         bus.wb_regwrite, bus.wb_rd, bus.wb_data);
  assign fwdRt = forward(rt_q, rtData_q, bus.exm_regwrite, bus.exm_rd, bus.exm_result,
                         bus.wb_regwrite, bus.wb_rd, bus.wb_data);

  assign bus.id_ready      = idReady;
  assign bus.ex_valid      = valid_q;
  assign bus.ex_a          = fwdRs;
  assign bus.ex_b          = alusrc_q ? imm_q : fwdRt;
  assign bus.ex_store_data = fwdRt;
  assign bus.ex_aluop      = aluop_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_regwrite   = valid_q & regwrite_q;
  assign bus.ex_memread    = valid_q & memread_q;
  assign bus.stall_cnt     = stallCnt_q;
endmodule
